rffe_spi_arbiter: RTL and testbench
===================================

RFFE_SPI_ARBITER -- requirements
Module: rffe_spi_arbiter

Interface
REQ-001 Parameter DATA_W, default 54, SPI payload width in bits; matches the SPI master data_depth.
REQ-002 Parameter TIMEOUT_CYC, default 4096, maximum clk cycles allowed in each wait state.
REQ-003 clk  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-requester transaction request, level; held until done or err.
REQ-006 req_dir0, req_dir1  in  1 each  requester transfer direction.
REQ-007 req_depth0, req_depth1  in  8 each  requester bit count.
REQ-008 req_data0, req_data1  in  DATA_W each  requester payload.
REQ-009 gnt  out  2  one-hot grant; high from arbitration until release.
REQ-010 done  out  2  one-cycle pulse to the granted requester on successful completion.
REQ-011 err  out  2  one-cycle pulse to the granted requester on reject or timeout.
REQ-012 spi_start  out  1  one-cycle launch pulse to the SPI master.
REQ-013 spi_dir, spi_data_depth, spi_data_tx  out  1/8/DATA_W  latched transaction fields.
REQ-014 spi_ready  in  2  SPI master status; bit0=idle level, bit1=end-of-transfer one-cycle pulse.

Function
REQ-015 The FSM SHALL use states IDLE, CHECK, LAUNCH, WAIT_ACC, WAIT_DONE, RELEASE.
REQ-016 In IDLE with req!=0 and spi_ready[0]=1, the block SHALL grant one requester and go to CHECK on the next edge.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins.
REQ-018 At grant, the block SHALL latch dir/depth/data of the winner; later changes to req_* inputs SHALL be ignored until RELEASE.
REQ-019 CHECK: a depth of 0 or a depth greater than DATA_W SHALL pulse err for the granted requester, SHALL not assert spi_start, and SHALL go to RELEASE; otherwise the FSM SHALL go to LAUNCH.
REQ-020 LAUNCH SHALL assert spi_start for exactly one cycle and SHALL go to WAIT_ACC; spi_* fields SHALL be stable from CHECK through WAIT_DONE.
REQ-021 WAIT_ACC: spi_ready[0]=0 SHALL move the FSM to WAIT_DONE; if spi_ready[1] pulses in the same cycle, the FSM SHALL go directly to RELEASE with done.
REQ-022 WAIT_DONE: spi_ready[1]=1 SHALL pulse done for the granted requester and SHALL move the FSM to RELEASE.
REQ-023 A 16-bit cycle counter SHALL clear on entry to WAIT_ACC and WAIT_DONE; reaching TIMEOUT_CYC SHALL pulse err and move the FSM to RELEASE.
REQ-024 RELEASE SHALL deassert gnt, update the round-robin pointer, and return to IDLE; minimum request-to-request spacing is one IDLE cycle.
REQ-025 Deassertion of req while granted SHALL NOT abort the transaction; done/err SHALL still be issued.
REQ-026 done and err SHALL never both be asserted; each SHALL be asserted only on the granted requester's bit.
REQ-027 Total latency from req to spi_start SHALL be 3 cycles when the SPI master is idle.

Reset
REQ-028 On rst_n low, the block SHALL immediately force: state=IDLE; gnt, done, err, spi_start, spi_dir, spi_data_depth, spi_data_tx, counter = 0; pointer = requester 1 as last granted.
REQ-029 Reset mid-transaction SHALL discard it silently, with no done/err pulse, and the SPI master SHALL be reset by the same rst_n.

Structure
REQ-030 State encodings, the requester count (2), and the spi_ready bit indices SHALL live in a shared package, rffe_pkg.
REQ-031 One sub-module, rr_arb2 (2-input round-robin arbiter with pointer register), SHALL be instantiated; everything else SHALL be flat.

Verification
REQ-032 req=01, depth=24, data=0x123456 -> spi_start 3 cycles later, spi_data_tx=0x123456; model spi_ready[1] pulse -> done=01, gnt=00.
REQ-033 req=11 held across three transactions -> grants 01,10,01 in that order.
REQ-034 req=10 with depth=0 and a separate transaction with depth=55 -> err=10 for each, spi_start never asserted.
REQ-035 spi_ready stuck at 01 after launch (never leaves idle), TIMEOUT_CYC=16 -> err pulse 16 cycles after entering WAIT_ACC, FSM returns to IDLE.
REQ-036 rst_n low during WAIT_DONE -> all outputs 0 asynchronously; after release, req=11 grants requester 0 first.
REQ-037 req_data0 changed during WAIT_DONE -> spi_data_tx unchanged; req0 dropped mid-transfer -> done still pulses.

Source files
------------

// File: rtl/rffe_pkg.sv
// Shared definitions for the RFFE SPI arbiter slice.
//   - FSM state encoding used by rffe_spi_arbiter
//   - requester count and spi_ready bit positions
//   - depth_valid(): accepts a bit count for a DATA_W-wide SPI master
package rffe_pkg;

  localparam int NUM_REQ  = 2;
  localparam int RDY_IDLE = 0;  // spi_ready bit: master idle (level)
  localparam int RDY_EOT  = 1;  // spi_ready bit: end of transfer (pulse)
  localparam int CNT_W    = 16; // wait-state cycle counter width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_ACC  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  // A transfer must move at least one bit and no more than the payload holds.
  function automatic logic depth_valid(input logic [7:0] depth, input int data_w);
    return (depth != 8'd0) && (int'(depth) <= data_w);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with its own last-granted pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (one bit per requester)
//   update     : load the pointer with upd_idx (the requester just served)
//   upd_idx    : index of the requester to record as last granted
//   gnt        : one-hot winner for the current request vector (combinational)
//   gnt_idx    : index of the winner
//   any_req    : at least one request is pending
// The pointer comes out of reset as "requester 1 was last", so requester 0
// wins the first simultaneous request.
module rr_arb2
  import rffe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic               upd_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_idx,
  output logic               any_req
);

  logic last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (update) begin
      last_reg <= upd_idx;
    end
  end

  assign any_req = |req;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign gnt_idx = (req == 2'b11) ? ~last_reg : req[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = any_req && (gnt_idx == 1'(gi));
    end
  endgenerate

endmodule

// File: rtl/rffe_spi_arbiter.sv
// Arbitrates two RFFE requesters onto one SPI master.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req[1:0]             : per-requester request level, held until done/err
//   req_dir*/depth*/data*: per-requester transaction fields
//   gnt[1:0]             : one-hot grant, high from arbitration until release
//   done[1:0], err[1:0]  : one-cycle completion / failure pulse to the owner
//   spi_start            : one-cycle launch pulse to the SPI master
//   spi_dir, spi_data_depth, spi_data_tx : fields latched at grant
//   spi_ready[1:0]       : bit0 master idle (level), bit1 end-of-transfer pulse
// All outputs are registered. spi_start is driven from LAUNCH and is visible
// during the first WAIT_ACC cycle, giving three clocks from req to spi_start.
// gnt drops on the same edge that raises done/err so the owner sees both
// together; the round-robin pointer advances during RELEASE.
module rffe_spi_arbiter
  import rffe_pkg::*;
#(
  parameter int DATA_W      = 54,
  parameter int TIMEOUT_CYC = 4096
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               req_dir0,
  input  logic               req_dir1,
  input  logic [7:0]         req_depth0,
  input  logic [7:0]         req_depth1,
  input  logic [DATA_W-1:0]  req_data0,
  input  logic [DATA_W-1:0]  req_data1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               spi_start,
  output logic               spi_dir,
  output logic [7:0]         spi_data_depth,
  output logic [DATA_W-1:0]  spi_data_tx,
  input  logic [1:0]         spi_ready
);

  // Last counter value before the wait budget is exhausted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]  done_reg, done_next;
  logic [NUM_REQ-1:0]  err_reg, err_next;
  logic                spi_start_reg, spi_start_next;
  logic                spi_dir_reg, spi_dir_next;
  logic [7:0]          spi_depth_reg, spi_depth_next;
  logic [DATA_W-1:0]   spi_data_reg, spi_data_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                owner_reg, owner_next;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_idx;
  logic                arb_any;
  logic                arb_update;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .update  (arb_update),
    .upd_idx (owner_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      spi_start_reg <= 1'b0;
      spi_dir_reg   <= 1'b0;
      spi_depth_reg <= '0;
      spi_data_reg  <= '0;
      cnt_reg       <= '0;
      owner_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      spi_start_reg <= spi_start_next;
      spi_dir_reg   <= spi_dir_next;
      spi_depth_reg <= spi_depth_next;
      spi_data_reg  <= spi_data_next;
      cnt_reg       <= cnt_next;
      owner_reg     <= owner_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    done_next      = '0;
    err_next       = '0;
    spi_start_next = 1'b0;
    spi_dir_next   = spi_dir_reg;
    spi_depth_next = spi_depth_reg;
    spi_data_next  = spi_data_reg;
    cnt_next       = cnt_reg;
    owner_next     = owner_reg;
    arb_update     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_any && spi_ready[RDY_IDLE]) begin
          gnt_next       = arb_gnt;
          owner_next     = arb_idx;
          // Fields are captured once here; the requester may change them freely
          // afterwards without disturbing the transfer in flight.
          spi_dir_next   = arb_idx ? req_dir1   : req_dir0;
          spi_depth_next = arb_idx ? req_depth1 : req_depth0;
          spi_data_next  = arb_idx ? req_data1  : req_data0;
          state_next     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!depth_valid(spi_depth_reg, DATA_W)) begin
          err_next   = gnt_reg;
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end else begin
          state_next = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        spi_start_next = 1'b1;
        cnt_next       = '0;
        state_next     = ST_WAIT_ACC;
      end

      ST_WAIT_ACC: begin
        // A very short transfer can end before idle is ever seen low.
        if (spi_ready[RDY_EOT]) begin
          done_next  = gnt_reg;
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end else if (!spi_ready[RDY_IDLE]) begin
          cnt_next   = '0;
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = gnt_reg;
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (spi_ready[RDY_EOT]) begin
          done_next  = gnt_reg;
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = gnt_reg;
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RELEASE: begin
        gnt_next   = '0;
        arb_update = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        gnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign gnt            = gnt_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign spi_start      = spi_start_reg;
  assign spi_dir        = spi_dir_reg;
  assign spi_data_depth = spi_depth_reg;
  assign spi_data_tx    = spi_data_reg;

endmodule

// File: tb/tb_rffe_spi_arbiter.sv
// Directed bench for rffe_spi_arbiter: reset values, round-robin order,
// depth rejection, early end-of-transfer, timeout, field latching,
// request drop mid-transfer and asynchronous reset mid-transfer.
module tb_rffe_spi_arbiter;

  localparam int DATA_W      = 54;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req;
  logic              req_dir0, req_dir1;
  logic [7:0]        req_depth0, req_depth1;
  logic [DATA_W-1:0] req_data0, req_data1;
  logic [1:0]        gnt, done, err;
  logic              spi_start, spi_dir;
  logic [7:0]        spi_data_depth;
  logic [DATA_W-1:0] spi_data_tx;
  logic [1:0]        spi_ready;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int start_snap;

  rffe_spi_arbiter #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_dir0       (req_dir0),
    .req_dir1       (req_dir1),
    .req_depth0     (req_depth0),
    .req_depth1     (req_depth1),
    .req_data0      (req_data0),
    .req_data1      (req_data1),
    .gnt            (gnt),
    .done           (done),
    .err            (err),
    .spi_start      (spi_start),
    .spi_dir        (spi_dir),
    .spi_data_depth (spi_data_depth),
    .spi_data_tx    (spi_data_tx),
    .spi_ready      (spi_ready)
  );

  always #5 clk = ~clk;

  // Running count of cycles with spi_start high.
  always @(posedge clk) begin
    if (spi_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer with an SPI model that goes busy one cycle after launch
  // and signals end-of-transfer one cycle later. Starts and ends in IDLE.
  task automatic do_txn(input string tag, input logic [1:0] exp_gnt,
                        input logic [63:0] exp_data);
    tick();
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    tick();
    tick();
    check({tag, "_start"}, 64'(spi_start), 64'd1);
    check({tag, "_data"}, 64'(spi_data_tx), exp_data);
    spi_ready = 2'b00;
    tick();
    spi_ready = 2'b11;
    tick();
    check({tag, "_done"}, 64'(done), 64'(exp_gnt));
    check({tag, "_gntoff"}, 64'(gnt), 64'd0);
    spi_ready = 2'b01;
    tick();
    $display("txn %s gnt=%b data=%0h", tag, exp_gnt, exp_data);
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 2'b00;
    req_dir0   = 1'b0;
    req_dir1   = 1'b0;
    req_depth0 = 8'd0;
    req_depth1 = 8'd0;
    req_data0  = '0;
    req_data1  = '0;
    spi_ready  = 2'b01;

    // Reset state
    repeat (3) tick();
    check("rst_gnt",   64'(gnt),         64'd0);
    check("rst_done",  64'(done),        64'd0);
    check("rst_err",   64'(err),         64'd0);
    check("rst_start", 64'(spi_start),   64'd0);
    check("rst_data",  64'(spi_data_tx), 64'd0);
    rst_n = 1'b1;
    tick();

    // Round robin with both requesting: 01, 10, 01
    req_dir0 = 1'b0; req_depth0 = 8'd8;  req_data0 = 54'h0A0A;
    req_dir1 = 1'b1; req_depth1 = 8'd12; req_data1 = 54'h0B0B;
    req = 2'b11;
    do_txn("rr1", 2'b01, 64'h0A0A);
    do_txn("rr2", 2'b10, 64'h0B0B);
    do_txn("rr3", 2'b01, 64'h0A0A);
    req = 2'b00;
    tick();

    // Basic transfer, latency, field latch, request dropped mid-transfer
    req_dir0 = 1'b1; req_depth0 = 8'd24; req_data0 = 54'h123456;
    req = 2'b01;
    tick();
    check("a_gnt_chk",   64'(gnt),       64'b01);
    check("a_start_c1",  64'(spi_start), 64'd0);
    tick();
    check("a_start_c2",  64'(spi_start), 64'd0);
    tick();
    check("a_start_c3",  64'(spi_start), 64'd1);
    check("a_data",      64'(spi_data_tx),    64'h123456);
    check("a_depth",     64'(spi_data_depth), 64'd24);
    check("a_dir",       64'(spi_dir),        64'd1);
    spi_ready = 2'b00;
    req_data0 = 54'hABCDEF;
    req = 2'b00;
    tick();
    check("a_start_1cy", 64'(spi_start),   64'd0);
    check("a_data_hold", 64'(spi_data_tx), 64'h123456);
    check("a_gnt_hold",  64'(gnt),         64'b01);
    tick();
    check("a_no_done",   64'(done), 64'd0);
    spi_ready = 2'b11;
    tick();
    check("a_done",      64'(done), 64'b01);
    check("a_gnt_off",   64'(gnt),  64'b00);
    check("a_no_err",    64'(err),  64'b00);
    spi_ready = 2'b01;
    tick();
    check("a_done_1cy",  64'(done), 64'd0);
    $display("txn basic done=01");

    // Depth rejection: 0 and 55
    start_snap = start_cnt;
    req_depth1 = 8'd0;
    req = 2'b10;
    tick();
    check("c0_gnt", 64'(gnt), 64'b10);
    tick();
    check("c0_err",  64'(err),  64'b10);
    check("c0_done", 64'(done), 64'b00);
    check("c0_gnt_off", 64'(gnt), 64'b00);
    req = 2'b00;
    tick();
    check("c0_err_1cy", 64'(err), 64'b00);
    $display("txn depth0 err=10");
    req_depth1 = 8'd55;
    req = 2'b10;
    tick();
    check("c55_gnt", 64'(gnt), 64'b10);
    tick();
    check("c55_err", 64'(err), 64'b10);
    req = 2'b00;
    tick();
    tick();
    check("c_no_start", 64'(start_cnt), 64'(start_snap));
    $display("txn depth55 err=10");

    // Depth = DATA_W is legal; end-of-transfer while still idle goes straight to release
    req_depth1 = 8'd54; req_data1 = 54'h3FFFFFFFFFFFFF;
    req = 2'b10;
    tick();
    tick();
    tick();
    check("b54_start", 64'(spi_start),   64'd1);
    check("b54_data",  64'(spi_data_tx), 64'h3FFFFFFFFFFFFF);
    spi_ready = 2'b11;
    req = 2'b00;
    tick();
    check("b54_done", 64'(done), 64'b10);
    check("b54_gnt",  64'(gnt),  64'b00);
    spi_ready = 2'b01;
    tick();
    $display("txn depth54 early-eot done=10");

    // Timeout: master never leaves idle after launch
    req_depth0 = 8'd8;
    req = 2'b01;
    tick();
    tick();
    tick();
    check("to_start", 64'(spi_start), 64'd1);
    req = 2'b00;
    repeat (15) tick();
    check("to_err_early", 64'(err), 64'b00);
    check("to_gnt_held",  64'(gnt), 64'b01);
    tick();
    check("to_err",     64'(err),  64'b01);
    check("to_no_done", 64'(done), 64'b00);
    check("to_gnt_off", 64'(gnt),  64'b00);
    tick();
    tick();
    check("to_err_1cy", 64'(err), 64'b00);
    check("to_idle_gnt", 64'(gnt), 64'b00);
    $display("txn timeout err=01");

    // Asynchronous reset during WAIT_DONE, then fresh arbitration
    req_dir0 = 1'b1; req_depth0 = 8'd16; req_data0 = 54'h55AA;
    req = 2'b01;
    tick();
    tick();
    tick();
    check("r_start", 64'(spi_start), 64'd1);
    spi_ready = 2'b00;
    tick();
    check("r_gnt_pre", 64'(gnt), 64'b01);
    #1 rst_n = 1'b0;
    #1;
    check("r_gnt",   64'(gnt),            64'd0);
    check("r_data",  64'(spi_data_tx),    64'd0);
    check("r_depth", 64'(spi_data_depth), 64'd0);
    check("r_dir",   64'(spi_dir),        64'd0);
    check("r_done",  64'(done),           64'd0);
    check("r_err",   64'(err),            64'd0);
    tick();
    rst_n = 1'b1;
    spi_ready = 2'b01;
    req = 2'b11;
    tick();
    check("r_first_gnt", 64'(gnt),  64'b01);
    check("r_no_done",   64'(done), 64'b00);
    check("r_no_err",    64'(err),  64'b00);
    $display("txn reset-mid-transfer regrant=01");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
